sram_like_slave: RTL and testbench
==================================

Name: sram_like_slave

Overview:
- Memory-side responder for the CPU's SRAM-like bus: the target end of the request/response protocol the core drives for instruction fetch and data access.
- Holds a word-addressed memory array and accepts pipelined requests via req/addr_ok.
- Returns responses in order via data_ok/rdata after a programmable latency.
- Used as the bench memory model when the core moves from the always-ready SRAM port to the handshaked interface.

Parameters:
- AW, 12: word-address width; the array holds 2^AW 32-bit words, indexed by addr[AW+1:2].
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.
- DEPTH, 2: maximum outstanding accepted-but-unanswered requests; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- req  in  1  master presents a request this cycle.
- wr  in  1  1 = write, 0 = read; qualified by req.
- size  in  2  transfer size: 0 = byte, 1 = half, 2 = word; informational only, strobes govern writes.
- wstrb  in  4  byte enables for writes; bit i writes wdata[8i+7:8i].
- addr  in  32  byte address; only bits [AW+1:2] are used.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle pulse; the head request completes.
- rdata  out  32  read data, valid while data_ok is high for a read; 0 for write responses.

Behaviour:
- Reset: queue emptied, count=0, data_ok=0, rdata=0, addr_ok=1 in the cycle after reset deasserts. Array contents are not reset and persist across reset.
- Reset mid-operation: all outstanding requests are discarded; no data_ok is issued for them.
- Acceptance: handshake fires at edge T when req & addr_ok.
  - addr_ok = (count < DEPTH), combinational from count only; it does not depend on req or on a same-cycle pop.
- Write commit: on acceptance edge T, for each i with wstrb[i]=1, mem[idx] byte i <= wdata byte i. wstrb=0 writes nothing.
- Read capture: on acceptance edge T the entry captures mem[idx] (value before the same-edge write, if any).
  - Every request reads the array state left by all previously accepted requests (read-after-write correct by in-order commit).
- Queue entry fields: {valid, is_write, data[31:0], cnt[3:0]}. FIFO with head/tail pointers wrapping modulo DEPTH.
- Countdown:
  - New entry loads cnt = LATENCY-1 (plus extra delay, see Optional Feature).
  - Every valid entry with cnt != 0 decrements each cycle; cnt saturates at 0.
- Response:
  - data_ok = head.valid & head.cnt == 0, registered-state derived.
  - rdata = head.is_write ? 0 : head.data while data_ok, else 0.
  - The head pops at the edge ending the data_ok cycle. The master has no back-pressure; it must accept every response.
- Timing: with LATENCY=L and no contention, a request accepted at edge T gives data_ok high in the cycle following edge T+L-1. L=1 gives data_ok the cycle right after acceptance.
- Ordering: responses are strictly in acceptance order. Later entries that reach cnt=0 wait behind the head and then complete on consecutive cycles, one per cycle.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Full: count==DEPTH gives addr_ok=0. req is ignored and wr/addr/wdata are not sampled; the master holds the request.

Optional Feature:
- SRAM_RAND_DELAY_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - Each accepted entry loads cnt = LATENCY-1 + lfsr[1:0], so 0..3 extra cycles.
  - LATENCY max becomes 12 so cnt fits in 4 bits.
  - Ordering rules are unchanged.
- Undefined: fixed latency exactly as above; no LFSR logic is present.

Test Plan:
- Reset: assert reset 3 cycles, release -> addr_ok=1, data_ok=0, rdata=0 immediately after.
- Word write then read (LATENCY=2): write addr 0x1c000010, wstrb 4'hF, wdata 0x12345678, accepted at edge 0; read same addr accepted at edge 1.
  - Write: data_ok in cycle after edge 1, rdata=0.
  - Read: data_ok next cycle, rdata=0x12345678.
- Byte strobes: preload 0xFFFFFFFF; write wstrb 4'b0101, wdata 0xAABBCCDD; read -> 0xFFBBFFDD.
- Full / back-pressure (DEPTH=2, LATENCY=4): three consecutive reads with req held.
  - addr_ok drops after two acceptances; third accepted the cycle after the first data_ok.
  - Data returns in order.
- Back-to-back (LATENCY=1): reads every cycle to 0x0,0x4,0x8 holding 1,2,3 -> data_ok high 3 consecutive cycles, rdata 1,2,3, addr_ok never drops.
- Mid-flight reset: two reads outstanding, reset 1 cycle -> no data_ok afterwards; memory still returns the previously written values on re-read.

Source files
------------

// File: rtl/sram_like_slave_if.sv
// SRAM-like request/response bus between a core (master) and a memory responder (slave).
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// Word-addressed memory answering SRAM-like requests in order; data_ok LATENCY cycles after acceptance.
// Up to DEPTH requests outstanding, addr_ok drops when full; SRAM_RAND_DELAY_EN adds 0..3 random cycles.
// Responses cannot be stalled: the master must take every data_ok pulse.
module sram_like_slave #(
  parameter int AW      = 12,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  sram_like_slave_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      mem [2**AW];
  logic [DEPTH-1:0] q_vld;
  logic             q_wr  [DEPTH];
  logic [31:0]      q_dat [DEPTH];
  logic [3:0]       q_cnt [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic [AW-1:0]    idx;
  logic             push;
  logic             pop;
  logic [3:0]       cnt_load;
  logic             unused_bits;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx          = bus.addr[AW+1:2];
  assign unused_bits  = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

  assign bus.addr_ok  = (count < CW'(DEPTH));
  assign bus.data_ok  = q_vld[head] && (q_cnt[head] == 4'd0);
  assign bus.rdata    = (bus.data_ok && !q_wr[head]) ? q_dat[head] : 32'd0;

  assign push = bus.req && bus.addr_ok && !reset;
  assign pop  = bus.data_ok;

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign cnt_load = 4'(LATENCY - 1) + {2'b00, lfsr[1:0]};
`else
  assign cnt_load = 4'(LATENCY - 1);
`endif

  // Array contents survive reset; writes commit in acceptance order so later reads see them.
  always_ff @(posedge clk) begin
    if (push && bus.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_wr[i]  <= 1'b0;
        q_dat[i] <= 32'd0;
        q_cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i] && (q_cnt[i] != 4'd0)) begin
          q_cnt[i] <= q_cnt[i] - 4'd1;
        end
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= nxt(head);
      end
      // Read data is captured before this edge's own write lands.
      if (push) begin
        q_vld[tail] <= 1'b1;
        q_wr[tail]  <= bus.wr;
        q_dat[tail] <= mem[idx];
        q_cnt[tail] <= cnt_load;
        tail        <= nxt(tail);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three latency configurations, directed scenarios plus a randomized run.
module tb_sram_like_slave;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sram_like_slave_if b1();
  sram_like_slave_if b2();
  sram_like_slave_if b4();

  sram_like_slave #(.AW(12), .LATENCY(1), .DEPTH(2)) u_l1 (.clk(clk), .reset(reset), .bus(b1));
  sram_like_slave #(.AW(12), .LATENCY(2), .DEPTH(2)) u_l2 (.clk(clk), .reset(reset), .bus(b2));
  sram_like_slave #(.AW(12), .LATENCY(4), .DEPTH(2)) u_l4 (.clk(clk), .reset(reset), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] fa [3];
  logic [31:0] fv [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single write into an idle instance, then enough idle cycles for its response to drain.
  task automatic write_wait(input int sel, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    case (sel)
      1:       begin b1.req = 1; b1.wr = 1; b1.addr = a; b1.wstrb = s; b1.wdata = d; end
      2:       begin b2.req = 1; b2.wr = 1; b2.addr = a; b2.wstrb = s; b2.wdata = d; end
      default: begin b4.req = 1; b4.wr = 1; b4.addr = a; b4.wstrb = s; b4.wdata = d; end
    endcase
    tick();
    b1.req = 0; b2.req = 0; b4.req = 0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    checks++; if (b2.addr_ok !== 1'b1) begin errors++; $display("FAIL reset_addr_ok got %b want 1", b2.addr_ok); end
    checks++; if (b2.data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got %b want 0", b2.data_ok); end
    checks++; if (b2.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", b2.rdata); end
    checks++; if (b1.addr_ok !== 1'b1 || b1.data_ok !== 1'b0) begin errors++; $display("FAIL reset_l1 got aok %b dok %b want 1 0", b1.addr_ok, b1.data_ok); end
    checks++; if (b4.addr_ok !== 1'b1 || b4.data_ok !== 1'b0) begin errors++; $display("FAIL reset_l4 got aok %b dok %b want 1 0", b4.addr_ok, b4.data_ok); end
  endtask

  task automatic test_write_read();
    b2.req = 1; b2.wr = 1; b2.addr = 32'h1c000010; b2.wstrb = 4'hF; b2.wdata = 32'h12345678;
    tick();
    b2.wr = 0; b2.wstrb = 4'h0;
    checks++; if (b2.data_ok !== 1'b0) begin errors++; $display("FAIL wr_rd_early got %b want 0", b2.data_ok); end
    tick();
    b2.req = 0;
    checks++; if (b2.data_ok !== 1'b1 || b2.rdata !== 32'd0) begin errors++; $display("FAIL wr_resp got dok %b rdata %h want 1 00000000", b2.data_ok, b2.rdata); end
    tick();
    checks++; if (b2.data_ok !== 1'b1 || b2.rdata !== 32'h12345678) begin errors++; $display("FAIL rd_resp got dok %b rdata %h want 1 12345678", b2.data_ok, b2.rdata); end
    tick();
    checks++; if (b2.data_ok !== 1'b0 || b2.rdata !== 32'd0) begin errors++; $display("FAIL rd_after got dok %b rdata %h want 0 0", b2.data_ok, b2.rdata); end
  endtask

  task automatic test_byte_strobe();
    int n;
    write_wait(2, 32'h1c000020, 4'hF, 32'hFFFFFFFF);
    write_wait(2, 32'h1c000020, 4'b0101, 32'hAABBCCDD);
    b2.req = 1; b2.wr = 0; b2.addr = 32'h1c000020;
    tick();
    b2.req = 0;
    n = 0;
    while (b2.data_ok !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (n >= 10) begin errors++; $display("FAIL strobe_timeout got no data_ok want data_ok"); end
    checks++; if (b2.rdata !== 32'hFFBBFFDD) begin errors++; $display("FAIL strobe_rdata got %h want ffbbffdd", b2.rdata); end
    tick();
  endtask

  task automatic test_full();
    int k;
    logic acc;
    logic [9:0]  exp_aok;
    logic [9:0]  exp_dok;
    logic [31:0] exp_rd;
    for (int i = 0; i < 3; i++) begin
      fa[i] = 32'h1c000300 + 32'(4 * i);
      fv[i] = $urandom;
      write_wait(4, fa[i], 4'hF, fv[i]);
    end
    // Bit e = value seen in the cycle after edge e (edge 0 accepts the first read).
    exp_aok = 10'b1111110001;
    exp_dok = 10'b0100011000;
    k = 0;
    b4.req = 1; b4.wr = 0; b4.addr = fa[0];
    for (int e = 0; e < 10; e++) begin
      acc = b4.req && b4.addr_ok;
      tick();
      if (acc) k++;
      if (k < 3) b4.addr = fa[k]; else b4.req = 0;
      exp_rd = (e == 3) ? fv[0] : (e == 4) ? fv[1] : (e == 8) ? fv[2] : 32'd0;
      checks++; if (b4.addr_ok !== exp_aok[e]) begin errors++; $display("FAIL full_addr_ok e%0d got %b want %b", e, b4.addr_ok, exp_aok[e]); end
      checks++; if (b4.data_ok !== exp_dok[e]) begin errors++; $display("FAIL full_data_ok e%0d got %b want %b", e, b4.data_ok, exp_dok[e]); end
      checks++; if (b4.rdata !== exp_rd) begin errors++; $display("FAIL full_rdata e%0d got %h want %h", e, b4.rdata, exp_rd); end
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL full_accepts got %0d want 3", k); end
    b4.req = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) write_wait(1, 32'(4 * i), 4'hF, 32'(i + 1));
    b1.req = 1; b1.wr = 0;
    for (int e = 0; e < 4; e++) begin
      b1.addr = 32'(4 * e);
      if (e == 3) b1.req = 0;
      checks++; if (b1.addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_addr_ok e%0d got %b want 1", e, b1.addr_ok); end
      tick();
      if (e < 3) begin
        checks++; if (b1.data_ok !== 1'b1 || b1.rdata !== 32'(e + 1)) begin errors++; $display("FAIL b2b_resp e%0d got dok %b rdata %h want 1 %h", e, b1.data_ok, b1.rdata, 32'(e + 1)); end
      end else begin
        checks++; if (b1.data_ok !== 1'b0) begin errors++; $display("FAIL b2b_tail got %b want 0", b1.data_ok); end
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] d;
    int          due;
  } exp_t;

  task automatic test_random();
    localparam int LAT = 2;
    localparam int DEP = 2;
    logic [31:0] mm [8];
    exp_t        q [$];
    exp_t        ent;
    int          cur, last_due, p_k;
    logic        p_req, p_wr, exp_aok, exp_dok;
    logic [3:0]  p_strb;
    logic [31:0] p_d, exp_rd;
    for (int k = 0; k < 8; k++) begin
      mm[k] = $urandom;
      write_wait(2, 32'h1c000200 + 32'(4 * k), 4'hF, mm[k]);
    end
    cur = 0; last_due = -1; p_req = 0; p_wr = 0; p_k = 0; p_strb = 0; p_d = 0;
    for (int i = 0; i < 400; i++) begin
      exp_aok = (q.size() < DEP);
      exp_dok = (q.size() > 0) && (q[0].due == cur);
      exp_rd  = (exp_dok && !q[0].w) ? q[0].d : 32'd0;
      checks++; if (b2.addr_ok !== exp_aok) begin errors++; $display("FAIL rand_addr_ok c%0d got %b want %b", cur, b2.addr_ok, exp_aok); end
      checks++; if (b2.data_ok !== exp_dok) begin errors++; $display("FAIL rand_data_ok c%0d got %b want %b", cur, b2.data_ok, exp_dok); end
      checks++; if (b2.rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata c%0d got %h want %h", cur, b2.rdata, exp_rd); end
      if (exp_dok) void'(q.pop_front());
      if (!p_req && i < 385) begin
        p_req  = ($urandom_range(0, 3) != 0);
        p_wr   = $urandom_range(0, 1) == 1;
        p_k    = $urandom_range(0, 7);
        p_strb = 4'($urandom_range(0, 15));
        p_d    = $urandom;
      end
      b2.req = p_req; b2.wr = p_wr; b2.addr = 32'h1c000200 + 32'(4 * p_k);
      b2.wstrb = p_strb; b2.wdata = p_d;
      if (p_req && exp_aok) begin
        ent.w = p_wr;
        ent.d = mm[p_k];
        ent.due = cur + LAT;
        if (ent.due <= last_due) ent.due = last_due + 1;
        last_due = ent.due;
        q.push_back(ent);
        if (p_wr) for (int b = 0; b < 4; b++) if (p_strb[b]) mm[p_k][8*b +: 8] = p_d[8*b +: 8];
        p_req = 0;
      end
      tick();
      cur++;
    end
    b2.req = 0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
  endtask

  task automatic test_mid_reset();
    int n;
    b4.req = 1; b4.wr = 0; b4.addr = fa[0];
    tick();
    b4.addr = fa[1];
    tick();
    b4.req = 0;
    reset = 1;
    tick();
    reset = 0;
    for (int e = 0; e < 8; e++) begin
      checks++; if (b4.data_ok !== 1'b0 || b4.rdata !== 32'd0) begin errors++; $display("FAIL midrst_quiet e%0d got dok %b rdata %h want 0 0", e, b4.data_ok, b4.rdata); end
      tick();
    end
    checks++; if (b4.addr_ok !== 1'b1) begin errors++; $display("FAIL midrst_addr_ok got %b want 1", b4.addr_ok); end
    b4.req = 1; b4.wr = 0; b4.addr = fa[1];
    tick();
    b4.req = 0;
    n = 0;
    while (b4.data_ok !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (n >= 10) begin errors++; $display("FAIL midrst_timeout got no data_ok want data_ok"); end
    checks++; if (b4.rdata !== fv[1]) begin errors++; $display("FAIL midrst_rdata got %h want %h", b4.rdata, fv[1]); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1;
    b1.req = 0; b1.wr = 0; b1.size = 2'd2; b1.wstrb = 0; b1.addr = 0; b1.wdata = 0;
    b2.req = 0; b2.wr = 0; b2.size = 2'd2; b2.wstrb = 0; b2.addr = 0; b2.wdata = 0;
    b4.req = 0; b4.wr = 0; b4.size = 2'd2; b4.wstrb = 0; b4.addr = 0; b4.wdata = 0;
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_full();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
